if_pc_gen: RTL and testbench

- Instruction-fetch front end; sits directly upstream of the IF/ID pipeline register.
- Holds the program counter, drives the instruction-memory fetch address, and predecodes the returned instruction.
- Predicts control flow: JAL always taken; B-type via a 2-bit saturating branch history table (BHT).
- Forwards pc/inst/jump_bp to IF/ID. Accepts redirects and BHT training from EX.

---
 rtl/if_pc_gen.sv | 137 +++++++++++++
 tb/tb_if_pc_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_gen.sv
// ----------------------------------------------------------------------------
// if_pc_gen: instruction-fetch front end feeding the IF/ID pipeline register.
//
// Holds the program counter, drives the instruction-memory fetch address and
// predecodes the returned instruction to predict control flow. JAL is always
// predicted taken; B-type branches use a table of 2-bit saturating counters
// indexed by pc[BHT_IDX_W+1:2]. EX redirects the pc and trains the table.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   id_hold_flag  in   pipeline stall, pc holds
//   ex_jump_flag  in   EX redirect (wins over hold)
//   ex_jump_addr  in   redirect target, loaded as-is
//   ex_bht_we     in   train the counter selected by ex_bht_pc
//   ex_bht_pc     in   pc of the resolved branch
//   ex_bht_taken  in   resolved outcome
//   inst_addr_o   out  fetch address (= pc)
//   inst_rdata_i  in   instruction returned combinationally for inst_addr_o
//   pc_o          out  pc of fetched instruction
//   inst_o        out  fetched instruction
//   jump_bp_o     out  instruction predicted taken
// ----------------------------------------------------------------------------
module if_pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BHT_IDX_W = 6,
    parameter logic [1:0]  BHT_INIT  = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_hold_flag,
    input  logic        ex_jump_flag,
    input  logic [31:0] ex_jump_addr,
    input  logic        ex_bht_we,
    input  logic [31:0] ex_bht_pc,
    input  logic        ex_bht_taken,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        jump_bp_o
);

    localparam int unsigned BhtEntries = 2 ** BHT_IDX_W;
    localparam logic [6:0]  OpJal      = 7'b1101111;
    localparam logic [6:0]  OpBranch   = 7'b1100011;

    logic [31:0]          pc_q, pc_d;
    logic [1:0]           bht_q [BhtEntries];

    logic [BHT_IDX_W-1:0] lkp_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [1:0]           upd_cur;
    logic [1:0]           upd_nxt;
    logic [31:0]          imm_j;
    logic [31:0]          imm_b;
    logic [31:0]          target;
    logic                 pred_taken;

    // Only the index bits of the training pc are meaningful.
    logic                 unused_bht_pc;
    assign unused_bht_pc = ^{ex_bht_pc[31:BHT_IDX_W+2], ex_bht_pc[1:0]};

    assign lkp_idx = pc_q[BHT_IDX_W+1:2];
    assign upd_idx = ex_bht_pc[BHT_IDX_W+1:2];

    assign imm_j = {{11{inst_rdata_i[31]}}, inst_rdata_i[31], inst_rdata_i[19:12],
                    inst_rdata_i[20], inst_rdata_i[30:21], 1'b0};
    assign imm_b = {{19{inst_rdata_i[31]}}, inst_rdata_i[31], inst_rdata_i[7],
                    inst_rdata_i[30:25], inst_rdata_i[11:8], 1'b0};

    // Predecode. The lookup reads the registered counter, so a same-cycle
    // update to the same index is only visible from the next cycle on.
    always_comb begin
        pred_taken = 1'b0;
        target     = pc_q + 32'd4;
        unique case (inst_rdata_i[6:0])
            OpJal: begin
                pred_taken = 1'b1;
                target     = pc_q + imm_j;
            end
            OpBranch: begin
                pred_taken = bht_q[lkp_idx][1];
                target     = pc_q + imm_b;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (ex_jump_flag) begin
            pc_d = ex_jump_addr;
        end else if (id_hold_flag) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = target;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Saturating counter update.
    assign upd_cur = bht_q[upd_idx];
    always_comb begin
        upd_nxt = upd_cur;
        if (ex_bht_taken) begin
            if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Training is independent of hold and redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BhtEntries; i++) begin
                bht_q[i] <= BHT_INIT;
            end
        end else if (ex_bht_we) begin
            bht_q[upd_idx] <= upd_nxt;
        end
    end

    assign inst_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_rdata_i;
    assign jump_bp_o   = pred_taken;

endmodule

// File: tb/tb_if_pc_gen.sv
module tb_if_pc_gen;

    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [31:0] Jal = 32'h0200_006F;  // jal x0, +0x20
    localparam logic [31:0] Beq = 32'hFE00_0CE3;  // beq x0, x0, -8

    typedef struct {
        logic [31:0] pc;
        logic        bp;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        id_hold_flag;
    logic        ex_jump_flag;
    logic [31:0] ex_jump_addr;
    logic        ex_bht_we;
    logic [31:0] ex_bht_pc;
    logic        ex_bht_taken;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        jump_bp_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    if_pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_hold_flag (id_hold_flag),
        .ex_jump_flag (ex_jump_flag),
        .ex_jump_addr (ex_jump_addr),
        .ex_bht_we    (ex_bht_we),
        .ex_bht_pc    (ex_bht_pc),
        .ex_bht_taken (ex_bht_taken),
        .inst_addr_o  (inst_addr_o),
        .inst_rdata_i (inst_rdata_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .jump_bp_o    (jump_bp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic bp);
        exp_t e;
        inst_rdata_i = inst;
        e.pc   = pc;
        e.bp   = bp;
        e.inst = inst;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty got 0 exp 1", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (pc_o === e.pc) else begin
            errors++;
            $error("FAIL %s pc_o got %h exp %h", tag, pc_o, e.pc);
        end
        checks++;
        assert (inst_addr_o === e.pc) else begin
            errors++;
            $error("FAIL %s inst_addr_o got %h exp %h", tag, inst_addr_o, e.pc);
        end
        checks++;
        assert (jump_bp_o === e.bp) else begin
            errors++;
            $error("FAIL %s jump_bp_o got %b exp %b", tag, jump_bp_o, e.bp);
        end
        checks++;
        assert (inst_o === e.inst) else begin
            errors++;
            $error("FAIL %s inst_o got %h exp %h", tag, inst_o, e.inst);
        end
    endtask

    // One fetch cycle: entered at a falling edge with controls already set.
    task automatic cyc(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                       input logic bp);
        push(inst, pc, bp);
        #1;
        check(tag);
        @(negedge clk);
        id_hold_flag = 1'b0;
        ex_jump_flag = 1'b0;
        ex_jump_addr = 32'h0;
        ex_bht_we    = 1'b0;
        ex_bht_pc    = 32'h0;
        ex_bht_taken = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken);
        ex_bht_we    = 1'b1;
        ex_bht_pc    = pc;
        ex_bht_taken = taken;
    endtask

    task automatic redirect(input logic [31:0] addr);
        ex_jump_flag = 1'b1;
        ex_jump_addr = addr;
    endtask

    initial begin
        rst_n        = 1'b0;
        id_hold_flag = 1'b0;
        ex_jump_flag = 1'b0;
        ex_jump_addr = 32'h0;
        ex_bht_we    = 1'b0;
        ex_bht_pc    = 32'h0;
        ex_bht_taken = 1'b0;
        inst_rdata_i = Nop;

        #2;
        push(Nop, 32'h0, 1'b0);
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch.
        cyc("seq0", Nop, 32'h00, 1'b0);
        cyc("seq4", Nop, 32'h04, 1'b0);
        cyc("seq8", Nop, 32'h08, 1'b0);
        cyc("seqc", Nop, 32'h0C, 1'b0);

        // JAL always predicted taken.
        cyc("jal", Jal, 32'h10, 1'b1);
        cyc("jal_tgt", Nop, 32'h30, 1'b0);
        cyc("nop34", Nop, 32'h34, 1'b0);
        cyc("nop38", Nop, 32'h38, 1'b0);
        cyc("nop3c", Nop, 32'h3C, 1'b0);

        // Fresh BEQ not taken; same-cycle training is not yet visible.
        train(32'h40, 1'b1);
        cyc("beq_fresh", Beq, 32'h40, 1'b0);
        redirect(32'h40);
        cyc("beq_fall", Nop, 32'h44, 1'b0);
        cyc("beq_trained", Beq, 32'h40, 1'b1);
        cyc("beq_tgt", Nop, 32'h38, 1'b0);

        // Saturation high at index of 0x80: 4 taken then 1 not-taken -> 10.
        train(32'h80, 1'b1);
        cyc("sat_t1", Nop, 32'h3C, 1'b0);
        train(32'h80, 1'b1);
        cyc("sat_t2", Nop, 32'h40, 1'b0);
        train(32'h80, 1'b1);
        cyc("sat_t3", Nop, 32'h44, 1'b0);
        train(32'h80, 1'b1);
        cyc("sat_t4", Nop, 32'h48, 1'b0);
        train(32'h80, 1'b0);
        cyc("sat_nt", Nop, 32'h4C, 1'b0);
        redirect(32'h80);
        cyc("sat_redir", Nop, 32'h50, 1'b0);
        cyc("sat_beq", Beq, 32'h80, 1'b1);

        // Saturation low at index of 0xC0: two not-taken then one taken -> 01.
        train(32'hC0, 1'b0);
        cyc("low_n1", Nop, 32'h78, 1'b0);
        train(32'hC0, 1'b0);
        cyc("low_n2", Nop, 32'h7C, 1'b0);
        train(32'hC0, 1'b1);
        cyc("low_t", Nop, 32'h80, 1'b0);
        redirect(32'hC0);
        cyc("low_redir", Nop, 32'h84, 1'b0);
        cyc("low_beq", Beq, 32'hC0, 1'b0);

        // pc + 4 wraps past the top of the address space.
        redirect(32'hFFFF_FFFC);
        cyc("wrap_redir", Nop, 32'hC4, 1'b0);
        cyc("wrap_top", Nop, 32'hFFFF_FFFC, 1'b0);
        redirect(32'h20);
        cyc("wrap_zero", Nop, 32'h0, 1'b0);

        // Hold beats prediction; redirect beats hold.
        id_hold_flag = 1'b1;
        cyc("hold1", Nop, 32'h20, 1'b0);
        id_hold_flag = 1'b1;
        cyc("hold2", Jal, 32'h20, 1'b1);
        id_hold_flag = 1'b1;
        cyc("hold3", Nop, 32'h20, 1'b0);
        id_hold_flag = 1'b1;
        redirect(32'h100);
        cyc("hold_redir", Nop, 32'h20, 1'b0);
        redirect(32'h80);
        cyc("redir_tgt", Nop, 32'h100, 1'b0);

        // Asynchronous reset mid-cycle with a trained BHT.
        push(Beq, 32'h80, 1'b1);
        #1;
        check("pre_reset");
        #1;
        rst_n = 1'b0;
        #1;
        push(Beq, 32'h0, 1'b0);
        check("async_reset");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        redirect(32'h80);
        cyc("post_reset", Nop, 32'h04, 1'b0);
        cyc("bht_cleared", Beq, 32'h80, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain got %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
